// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: status codes (also consumed
// by the LED decoder), coin value width and the FSM state type.
package vend_pkg;

    localparam int COIN_W = 4;

    localparam logic [2:0] CODE_OFF      = 3'b000;
    localparam logic [2:0] CODE_IDLE     = 3'b001;
    localparam logic [2:0] CODE_LOW      = 3'b010;
    localparam logic [2:0] CODE_EQ       = 3'b011;
    localparam logic [2:0] CODE_OVER     = 3'b100;
    localparam logic [2:0] CODE_DISPENSE = 3'b101;
    localparam logic [2:0] CODE_REFUND   = 3'b110;

    typedef enum logic [2:0] {
        ST_OFF      = CODE_OFF,
        ST_IDLE     = CODE_IDLE,
        ST_LOW      = CODE_LOW,
        ST_EQ       = CODE_EQ,
        ST_OVER     = CODE_OVER,
        ST_DISPENSE = CODE_DISPENSE,
        ST_REFUND   = CODE_REFUND
    } state_t;

    function automatic logic is_credit_state(input state_t s);
        return (s == ST_LOW) || (s == ST_EQ) || (s == ST_OVER);
    endfunction

endpackage

// File: rtl/vend_hold_timer.sv
// Loadable down-counter with a done flag; saturates at zero. Used for the
// DISPENSE/REFUND hold and for the inactivity timeout.
module vend_hold_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/vend_ctrl_fsm.sv
// Vending-machine control FSM producing the 3-bit status code.
// Optional inactivity timeout in credit states: define VEND_TIMEOUT_EN.
module vend_ctrl_fsm
    import vend_pkg::*;
#(
    parameter int PRICE         = 15,
    parameter int CREDIT_W      = 8,
    parameter int DISP_CYCLES   = 4,
    parameter int REFUND_CYCLES = 4
`ifdef VEND_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1000
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                power_btn,
    input  logic                coin_valid,
    input  logic [COIN_W-1:0]   coin_amt,
    input  logic                buy,
    input  logic                cancel,
    output logic [2:0]          status,
    output logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] change,
    output logic                change_valid,
    output logic                dispense,
    output logic                coin_reject
);

    localparam int HOLD_MAX = (DISP_CYCLES > REFUND_CYCLES) ? DISP_CYCLES : REFUND_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;
    localparam logic [HOLD_W-1:0]   DISP_LOAD   = HOLD_W'(DISP_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   REFUND_LOAD = HOLD_W'(REFUND_CYCLES - 1);
    localparam logic [CREDIT_W-1:0] PRICE_C     = CREDIT_W'(PRICE);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic                pend_q, pend_d;
    logic                dispense_q, dispense_d;
    logic                change_valid_q, change_valid_d;
    logic                coin_reject_q, coin_reject_d;

    logic                hold_load;
    logic [HOLD_W-1:0]   hold_val;
    logic                hold_en;
    logic                hold_done;
    logic                timeout_hit;
    logic                coin_present;
    logic [CREDIT_W:0]   coin_sum;

    function automatic state_t classify(input logic [CREDIT_W-1:0] c);
        if (c < PRICE_C) begin
            return ST_LOW;
        end else if (c == PRICE_C) begin
            return ST_EQ;
        end
        return ST_OVER;
    endfunction

    assign coin_present = coin_valid && (coin_amt != '0);
    assign coin_sum     = {1'b0, credit_q} + {{(CREDIT_W + 1 - COIN_W){1'b0}}, coin_amt};

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        change_d       = change_q;
        pend_d         = pend_q;
        dispense_d     = 1'b0;
        change_valid_d = 1'b0;
        coin_reject_d  = 1'b0;
        hold_load      = 1'b0;
        hold_val       = '0;
        hold_en        = 1'b0;

        case (state_q)
            ST_OFF: begin
                coin_reject_d = coin_present;
                if (power_btn) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (power_btn) begin
                    state_d       = ST_OFF;
                    coin_reject_d = coin_present;
                end else if (coin_present) begin
                    credit_d = {{(CREDIT_W - COIN_W){1'b0}}, coin_amt};
                    state_d  = classify({{(CREDIT_W - COIN_W){1'b0}}, coin_amt});
                end
            end

            ST_LOW, ST_EQ, ST_OVER: begin
                if (power_btn || cancel || timeout_hit) begin
                    change_d       = credit_q;
                    credit_d       = '0;
                    pend_d         = pend_q | power_btn;
                    state_d        = ST_REFUND;
                    change_valid_d = 1'b1;
                    hold_load      = 1'b1;
                    hold_val       = REFUND_LOAD;
                    coin_reject_d  = coin_present;
                end else if (buy && (state_q != ST_LOW)) begin
                    change_d      = credit_q - PRICE_C;
                    credit_d      = '0;
                    state_d       = ST_DISPENSE;
                    dispense_d    = 1'b1;
                    hold_load     = 1'b1;
                    hold_val      = DISP_LOAD;
                    coin_reject_d = coin_present;
                end else if (coin_present) begin
                    if (coin_sum[CREDIT_W]) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = classify(coin_sum[CREDIT_W-1:0]);
                    end
                end
            end

            ST_DISPENSE: begin
                coin_reject_d = coin_present;
                hold_en       = 1'b1;
                if (power_btn) begin
                    pend_d = 1'b1;
                end
                if (hold_done) begin
                    if (change_q != '0) begin
                        state_d        = ST_REFUND;
                        change_valid_d = 1'b1;
                        hold_load      = 1'b1;
                        hold_val       = REFUND_LOAD;
                    end else if (pend_d) begin
                        // No change to return, so a pending power-off is honoured here.
                        state_d = ST_OFF;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_REFUND: begin
                coin_reject_d = coin_present;
                hold_en       = 1'b1;
                if (power_btn) begin
                    pend_d = 1'b1;
                end
                if (hold_done) begin
                    change_d = '0;
                    state_d  = pend_d ? ST_OFF : ST_IDLE;
                    pend_d   = 1'b0;
                end
            end

            default: begin
                state_d  = ST_OFF;
                credit_d = '0;
                change_d = '0;
                pend_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_OFF;
            credit_q       <= '0;
            change_q       <= '0;
            pend_q         <= 1'b0;
            dispense_q     <= 1'b0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            change_q       <= change_d;
            pend_q         <= pend_d;
            dispense_q     <= dispense_d;
            change_valid_q <= change_valid_d;
            coin_reject_q  <= coin_reject_d;
        end
    end

    vend_hold_timer #(.W(HOLD_W)) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (hold_load),
        .load_val (hold_val),
        .en       (hold_en),
        .done     (hold_done)
    );

`ifdef VEND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic to_load;
    logic to_en;
    logic to_done;

    // Entry from IDLE and every accepted coin both change the credit value.
    assign to_load     = is_credit_state(state_d) && (credit_d != credit_q);
    assign to_en       = is_credit_state(state_q);
    assign timeout_hit = to_done && is_credit_state(state_q);

    vend_hold_timer #(.W(TO_W)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (to_load),
        .load_val (TO_W'(TIMEOUT_CYCLES - 1)),
        .en       (to_en),
        .done     (to_done)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    assign status       = state_q;
    assign credit       = credit_q;
    assign change       = change_q;
    assign change_valid = change_valid_q;
    assign dispense     = dispense_q;
    assign coin_reject  = coin_reject_q;

endmodule

// File: tb/tb_vend_ctrl_fsm.sv
// Directed testbench for vend_ctrl_fsm with hand-computed expectations.
module tb_vend_ctrl_fsm;

    logic       clk;
    logic       rst_n;
    logic       power_btn;
    logic       coin_valid;
    logic [3:0] coin_amt;
    logic       buy;
    logic       cancel;
    logic [2:0] status;
    logic [7:0] credit;
    logic [7:0] change;
    logic       change_valid;
    logic       dispense;
    logic       coin_reject;

    int n_total = 0;
    int n_bad   = 0;

    vend_ctrl_fsm dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .power_btn    (power_btn),
        .coin_valid   (coin_valid),
        .coin_amt     (coin_amt),
        .buy          (buy),
        .cancel       (cancel),
        .status       (status),
        .credit       (credit),
        .change       (change),
        .change_valid (change_valid),
        .dispense     (dispense),
        .coin_reject  (coin_reject)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver: apply one cycle of inputs, advance past the edge, clear inputs
    task automatic drive(input logic pb, input logic cn, input logic by,
                         input logic cv, input logic [3:0] amt);
        power_btn  = pb;
        cancel     = cn;
        buy        = by;
        coin_valid = cv;
        coin_amt   = amt;
        step();
        power_btn  = 1'b0;
        cancel     = 1'b0;
        buy        = 1'b0;
        coin_valid = 1'b0;
        coin_amt   = 4'd0;
    endtask

    task automatic coin(input logic [3:0] amt);
        drive(1'b0, 1'b0, 1'b0, 1'b1, amt);
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        power_btn  = 1'b0;
        coin_valid = 1'b0;
        coin_amt   = 4'd0;
        buy        = 1'b0;
        cancel     = 1'b0;
        step();
        step();
        check("rst_status", {29'd0, status}, 0);
        check("rst_credit", {24'd0, credit}, 0);
        check("rst_change", {24'd0, change}, 0);
        check("rst_cv", {31'd0, change_valid}, 0);
        check("rst_disp", {31'd0, dispense}, 0);
        check("rst_rej", {31'd0, coin_reject}, 0);
        rst_n = 1'b1;
        step();

        // power toggling
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        check("pwr_on", {29'd0, status}, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        check("pwr_off", {29'd0, status}, 0);
        coin(4'd5);
        check("off_coin_rej", {31'd0, coin_reject}, 1);
        check("off_coin_status", {29'd0, status}, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        check("pwr_on2", {29'd0, status}, 1);
        coin(4'd0);
        check("zero_coin_status", {29'd0, status}, 1);
        check("zero_coin_rej", {31'd0, coin_reject}, 0);

        // exact price, buy with no change
        coin(4'd5);
        check("c5_status", {29'd0, status}, 2);
        check("c5_credit", {24'd0, credit}, 5);
        coin(4'd5);
        check("c10_status", {29'd0, status}, 2);
        coin(4'd5);
        check("c15_status", {29'd0, status}, 3);
        check("c15_credit", {24'd0, credit}, 15);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("buy_eq_status", {29'd0, status}, 5);
        check("buy_eq_disp", {31'd0, dispense}, 1);
        check("buy_eq_credit", {24'd0, credit}, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("disp_hold", {29'd0, status}, 5);
            check("disp_pulse_low", {31'd0, dispense}, 0);
        end
        step();
        check("disp_exit_idle", {29'd0, status}, 1);
        check("disp_exit_change", {24'd0, change}, 0);

        // overpay, dispense then refund change
        coin(4'd10);
        check("c10b_status", {29'd0, status}, 2);
        coin(4'd10);
        check("c20_status", {29'd0, status}, 4);
        check("c20_credit", {24'd0, credit}, 20);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("buy_ov_status", {29'd0, status}, 5);
        check("buy_ov_change", {24'd0, change}, 5);
        for (int i = 0; i < 3; i++) begin
            step();
            check("disp2_hold", {29'd0, status}, 5);
        end
        step();
        check("ref_status", {29'd0, status}, 6);
        check("ref_change", {24'd0, change}, 5);
        check("ref_cv", {31'd0, change_valid}, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("ref_hold", {29'd0, status}, 6);
            check("ref_change_stable", {24'd0, change}, 5);
            check("ref_cv_low", {31'd0, change_valid}, 0);
        end
        step();
        check("ref_exit", {29'd0, status}, 1);
        check("ref_exit_change", {24'd0, change}, 0);

        // cancel beats buy and coin in the same cycle
        coin(4'd7);
        check("c7_credit", {24'd0, credit}, 7);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd3);
        check("cxl_status", {29'd0, status}, 6);
        check("cxl_change", {24'd0, change}, 7);
        check("cxl_rej", {31'd0, coin_reject}, 1);
        check("cxl_credit", {24'd0, credit}, 0);
        for (int i = 0; i < 3; i++) step();
        check("cxl_rej_clear", {31'd0, coin_reject}, 0);
        step();
        check("cxl_exit", {29'd0, status}, 1);

        // credit overflow boundary, then power-off during credit
        for (int i = 0; i < 16; i++) coin(4'd15);
        coin(4'd10);
        check("c250_credit", {24'd0, credit}, 250);
        check("c250_status", {29'd0, status}, 4);
        coin(4'd10);
        check("ovf_rej", {31'd0, coin_reject}, 1);
        check("ovf_credit", {24'd0, credit}, 250);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        check("pwr_ref_status", {29'd0, status}, 6);
        check("pwr_ref_change", {24'd0, change}, 250);
        for (int i = 0; i < 3; i++) step();
        step();
        check("pwr_ref_off", {29'd0, status}, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        check("pwr_on3", {29'd0, status}, 1);

        // buy ignored in LOW, then inactivity
        coin(4'd3);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("low_buy_status", {29'd0, status}, 2);
        check("low_buy_credit", {24'd0, credit}, 3);
`ifdef VEND_TIMEOUT_EN
        n = 0;
        while ((status != 3'b110) && (n < 1100)) begin
            step();
            n++;
        end
        check("to_status", {29'd0, status}, 6);
        check("to_change", {24'd0, change}, 3);
        check("to_window", {31'd0, (n >= 990) && (n <= 1010)}, 1);
        for (int i = 0; i < 4; i++) step();
        check("to_exit", {29'd0, status}, 1);
`else
        n = 0;
        repeat (1100) begin
            step();
            n++;
        end
        check("no_to_status", {29'd0, status}, 2);
        check("no_to_credit", {24'd0, credit}, 3);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) step();
        check("no_to_exit", {29'd0, status}, 1);
`endif

        // asynchronous reset in the middle of REFUND
        coin(4'd5);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        step();
        check("mid_ref_status", {29'd0, status}, 6);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_status", {29'd0, status}, 0);
        check("arst_change", {24'd0, change}, 0);
        check("arst_credit", {24'd0, credit}, 0);
        #1;
        rst_n = 1'b1;
        step();
        check("arst_stay_off", {29'd0, status}, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
